// File: rtl/if_fetch_queue.sv
// Purpose : RV32 instruction-fetch front end; owns the fetch PC, issues imem requests, buffers {pc, inst} pairs.
// Latency : first out_valid 2 cycles after rst rises (ack in the request cycle), then one instruction per cycle.
// Backpress: out_ready=0 holds the head stable; fetching pauses once the queue holds DEPTH entries.
//
// Ports:
//   clk, rst                 clock; asynchronous active-low reset
//   redirect_valid/_pc       EX branch/jump redirect (1-cycle pulse); flushes the queue
//   imem_req/_addr           outstanding fetch request and its address (stable until ack)
//   imem_ack/_rdata          memory response; may arrive in the cycle imem_req first rises
//   out_valid/_pc/_inst      head of the queue (first-word fall-through)
//   out_ready                IF/ID accepts the head; 0 = hazard stall
module if_fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        out_valid,
   output logic [31:0] out_pc,
   output logic [31:0] out_inst,
   input  logic        out_ready
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t          state;
   logic [31:0]     fpc;
   logic [31:0]     req_addr;
   logic [CW-1:0]   count;
   logic [AW-1:0]   rd_ptr;
   logic [AW-1:0]   wr_ptr;
   logic [31:0]     pc_mem   [DEPTH];
   logic [31:0]     inst_mem [DEPTH];

   logic            push;
   logic            pop;
   logic [CW-1:0]   count_next;
   logic [31:0]     redirect_tgt;
   logic [31:0]     fpc_inc;

   // Low two bits of the target are dropped: instructions are word aligned.
   assign redirect_tgt = redirect_pc & ~32'h0000_0003;
   assign fpc_inc      = fpc + 32'd4;

   assign pop        = out_valid & out_ready;
   // A response that coincides with a redirect is stale and never enters the queue.
   assign push       = (state == WAIT) & imem_ack & ~redirect_valid;
   assign count_next = count + CW'(push) - CW'(pop);

   assign imem_req  = (state != IDLE);
   assign imem_addr = req_addr;

   assign out_valid = (count != '0);
   assign out_pc    = out_valid ? pc_mem[rd_ptr]   : '0;
   assign out_inst  = out_valid ? inst_mem[rd_ptr] : '0;

   // Queue storage needs no reset: entries are only visible once count covers them.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr]   <= req_addr;
         inst_mem[wr_ptr] <= imem_rdata;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         fpc      <= RESET_PC;
         req_addr <= '0;
         count    <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
      end else begin
         // Queue bookkeeping: a redirect empties the queue and beats any same-cycle pop.
         if (redirect_valid) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
         end else begin
            count <= count_next;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
         end

         case (state)
            IDLE: begin
               if (redirect_valid) begin
                  fpc <= redirect_tgt;
               end else if (count < CW'(DEPTH)) begin
                  // Space check uses the current count; a pop this cycle only helps next cycle.
                  req_addr <= fpc;
                  state    <= WAIT;
               end
            end
            WAIT: begin
               if (imem_ack) begin
                  if (redirect_valid) begin
                     fpc   <= redirect_tgt;
                     state <= IDLE;
                  end else begin
                     fpc <= fpc_inc;
                     // Keep requesting back-to-back while the queue still has room after this push.
                     if (count_next < CW'(DEPTH)) begin
                        req_addr <= fpc_inc;
                     end else begin
                        state <= IDLE;
                     end
                  end
               end else if (redirect_valid) begin
                  // The memory still owes a response; wait it out and throw it away.
                  fpc   <= redirect_tgt;
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (redirect_valid) fpc <= redirect_tgt;
               if (imem_ack)       state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Purpose : self-checking bench for if_fetch_queue with a configurable-latency memory model.
// Latency : memory acks after 'lat' request cycles (0 = same cycle as the request).
// Backpress: out_ready driven directly by the directed stimulus.
module tb_if_fetch_queue;

   localparam logic [31:0] KEY = 32'hA5A5_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        out_valid;
   logic [31:0] out_pc;
   logic [31:0] out_inst;
   logic        out_ready;

   int   n_cmp = 0;
   int   n_err = 0;
   int   lat   = 0;
   int   mcnt  = 0;
   ent_t exp_q[$];
   ent_t mon_e;

   always #5 clk = ~clk;

   if_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .out_valid      (out_valid),
      .out_pc         (out_pc),
      .out_inst       (out_inst),
      .out_ready      (out_ready)
   );

   // Memory model: evaluated mid-cycle so a same-cycle ack is visible at the next rising edge.
   always @(negedge clk) begin
      if (!rst || !imem_req) begin
         imem_ack   = 1'b0;
         imem_rdata = '0;
         mcnt       = 0;
      end else begin
         if (imem_ack) mcnt = 0;
         if (mcnt >= lat) begin
            imem_ack   = 1'b1;
            imem_rdata = imem_addr ^ KEY;
         end else begin
            imem_ack = 1'b0;
            mcnt++;
         end
      end
   end

   // Monitor: every accepted head entry is checked against the scoreboard.
   always @(negedge clk) begin
      if (rst && out_valid && out_ready) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_out: got pc=%h inst=%h, required no output", out_pc, out_inst);
         end else begin
            mon_e = exp_q.pop_front();
            if (out_pc !== mon_e.pc || out_inst !== mon_e.inst) begin
               n_err++;
               $display("FAIL out_entry: got pc=%h inst=%h, required pc=%h inst=%h",
                        out_pc, out_inst, mon_e.pc, mon_e.inst);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", nm, act, req);
      end
   endtask

   task automatic expect_pc(input logic [31:0] pc);
      ent_t e;
      e.pc   = pc;
      e.inst = pc ^ KEY;
      exp_q.push_back(e);
   endtask

   task automatic wait_drain(input string nm);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         tick();
         n++;
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain_%s: got %0d entries outstanding, required 0", nm, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic do_reset();
      rst            = 1'b0;
      redirect_valid = 1'b0;
      out_ready      = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic release_rst();
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      imem_ack       = 1'b0;
      imem_rdata     = '0;
      redirect_pc    = '0;
      do_reset();

      // Reset state
      check("rst_imem_req",  {31'd0, imem_req},  32'd0);
      check("rst_imem_addr", imem_addr,          32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_pc",    out_pc,             32'd0);
      check("rst_out_inst",  out_inst,           32'd0);

      // Streaming with same-cycle ack and no stall
      lat = 0;
      for (int i = 0; i < 8; i++) expect_pc(32'(4 * i));
      out_ready = 1'b1;
      release_rst();
      tick();
      check("lat_valid_c1", {31'd0, out_valid}, 32'd0);
      tick();
      check("lat_valid_c2", {31'd0, out_valid}, 32'd1);
      wait_drain("stream");
      do_reset();

      // Stall fill: exactly DEPTH entries, request stops, then ordered release
      release_rst();
      repeat (10) tick();
      check("fill_imem_req",  {31'd0, imem_req},  32'd0);
      check("fill_out_valid", {31'd0, out_valid}, 32'd1);
      check("fill_head_pc",   out_pc,             32'd0);
      for (int i = 0; i < 5; i++) expect_pc(32'(4 * i));
      out_ready = 1'b1;
      wait_drain("fill");
      do_reset();

      // Redirect during a slow request: old request drains, response is dropped
      lat = 3;
      release_rst();
      tick();
      tick();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0100;
      tick();
      redirect_valid = 1'b0;
      check("drain_req",   {31'd0, imem_req}, 32'd1);
      check("drain_addr0", imem_addr,         32'd0);
      tick();
      check("drain_addr1", imem_addr,         32'd0);
      tick();
      check("drain_req_low", {31'd0, imem_req},  32'd0);
      check("drain_dropped", {31'd0, out_valid}, 32'd0);
      tick();
      check("redir_req",  {31'd0, imem_req}, 32'd1);
      check("redir_addr", imem_addr,         32'h0000_0100);
      expect_pc(32'h0000_0100);
      expect_pc(32'h0000_0104);
      out_ready = 1'b1;
      wait_drain("redir_slow");
      do_reset();

      // Redirect coincident with ack and with a pop
      lat = 0;
      expect_pc(32'h0000_0000);
      out_ready = 1'b1;
      release_rst();
      tick();
      tick();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0203;
      tick();
      redirect_valid = 1'b0;
      check("coinc_empty",   {31'd0, out_valid}, 32'd0);
      check("coinc_req_low", {31'd0, imem_req},  32'd0);
      tick();
      check("coinc_addr", imem_addr, 32'h0000_0200);
      expect_pc(32'h0000_0200);
      expect_pc(32'h0000_0204);
      wait_drain("coinc");
      do_reset();

      // Redirect from IDLE to the top of the address space; PC wraps to zero
      expect_pc(32'hFFFF_FFFC);
      expect_pc(32'h0000_0000);
      expect_pc(32'h0000_0004);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      rst            = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      tick();
      redirect_valid = 1'b0;
      check("wrap_idle_req", {31'd0, imem_req}, 32'd0);
      tick();
      check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
      wait_drain("wrap");
      do_reset();

      // Asynchronous reset in WAIT with two entries queued
      release_rst();
      tick();
      tick();
      tick();
      check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
      check("pre_rst_req",   {31'd0, imem_req},  32'd1);
      check("pre_rst_addr",  imem_addr,          32'h0000_0008);
      rst = 1'b0;
      #1;
      check("arst_out_valid", {31'd0, out_valid}, 32'd0);
      check("arst_out_pc",    out_pc,             32'd0);
      check("arst_out_inst",  out_inst,           32'd0);
      check("arst_imem_req",  {31'd0, imem_req},  32'd0);
      check("arst_imem_addr", imem_addr,          32'd0);
      repeat (2) @(posedge clk);
      expect_pc(32'h0000_0000);
      expect_pc(32'h0000_0004);
      out_ready = 1'b1;
      release_rst();
      tick();
      check("restart_req",  {31'd0, imem_req}, 32'd1);
      check("restart_addr", imem_addr,         32'h0000_0000);
      wait_drain("restart");
      do_reset();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Instruction-fetch front end for the 5-stage pipelined RV32 CPU. Sits directly upstream of the IF/ID pipeline register.
- Owns the fetch PC and issues requests to a variable-latency instruction memory over a req/ack handshake.
- Buffers fetched {pc, inst} pairs in a small FIFO and delivers them with valid/ready. Ready is driven low by hazard-detect stalls.
- Accepts branch/jump redirects from EX. A redirect flushes the queue and discards any in-flight response.

Parameters:
- DEPTH, 4, FIFO entries (power of two, >=2)
- RESET_PC, 32'h0000_0000, fetch PC after reset

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous reset, active-low (rst=0 resets; the CPU runs while rst=1)
- redirect_valid  input  1  branch taken / jump resolved in EX; 1-cycle pulse
- redirect_pc  input  32  target PC; bits [1:0] ignored, forced to 0
- imem_req  output  1  fetch request outstanding
- imem_addr  output  32  fetch address, stable while imem_req=1
- imem_ack  input  1  response valid; may assert in the same cycle imem_req first rises
- imem_rdata  input  32  instruction word, valid when imem_ack=1
- out_valid  output  1  head entry valid (FIFO non-empty)
- out_pc  output  32  PC of the head entry
- out_inst  output  32  instruction of the head entry
- out_ready  input  1  IF/ID accepts the head; 0 = stall

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, fpc=RESET_PC, req_addr=0, FIFO count=0, rd/wr pointers=0. Outputs: imem_req=0, imem_addr=0, out_valid=0, out_pc=0, out_inst=0.
- Output side:
  - out_valid = (count!=0); out_pc/out_inst are the head entry (first-word fall-through, no register delay).
  - Pop on the edge where out_valid & out_ready.
  - out_* hold stable while out_valid=1 and out_ready=0.
- FSM states: IDLE, WAIT, DRAIN. imem_req=1 in WAIT and DRAIN. imem_addr=req_addr.
- IDLE:
  - redirect_valid: fpc<=redirect_pc, FIFO cleared, stay IDLE.
  - else if count<DEPTH: req_addr<=fpc, go WAIT. The pop in this cycle is ignored for the space check.
- WAIT, no ack:
  - redirect_valid: go DRAIN, fpc<=redirect_pc, FIFO cleared.
  - else hold.
- WAIT, ack, no redirect:
  - Push {req_addr, imem_rdata}; fpc<=fpc+4.
  - If count_after_push_and_pop<DEPTH: req_addr<=fpc+4, stay WAIT (back-to-back, one instruction per cycle).
  - Else go IDLE.
- WAIT, ack with redirect_valid: response discarded, FIFO cleared, fpc<=redirect_pc, go IDLE.
- DRAIN: the request cannot be abandoned; imem_req and imem_addr hold until ack.
  - ack: data discarded, go IDLE.
  - redirect_valid: fpc<=new redirect_pc, stay DRAIN (or go IDLE if ack in the same cycle).
- Redirect vs pop in the same cycle: the redirect wins; FIFO empty next cycle.
- Flow-control invariant: a request is issued only when count<DEPTH. Count never increases while a request is outstanding, so a push never overflows.
- Push and pop in the same cycle: count unchanged.
- Latency: with ack in the cycle of request, the first out_valid comes 2 cycles after rst rises.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 = 0.
- Reset asserted mid-transaction drops everything immediately. The memory must tolerate imem_req falling without ack.

Test Plan:
- Reset, RESET_PC=0, ack same-cycle, rdata=addr^32'hA5A5_0000, out_ready=1 -> out_pc sequence 0,4,8,... one per cycle after the first; out_inst matches.
- out_ready=0 for 10 cycles, always-ack memory -> exactly 4 entries buffered (pc 0..12), imem_req low after fill. Release -> pcs 0,4,8,12,16 in order, no loss or duplication.
- Memory with 3-cycle ack latency, redirect_pc=32'h100 in the 2nd wait cycle -> imem_addr stays at the old addr until ack; that response is dropped. The next request is 32'h100; first out_pc=32'h100.
- Redirect to 32'h203 coincident with ack and with out_valid&out_ready -> FIFO empty next cycle; next imem_addr=32'h200.
- Redirect to 32'hFFFF_FFFC -> out_pc 32'hFFFF_FFFC then 32'h0000_0000.
- rst pulsed low while in WAIT with 2 entries queued -> outputs zero immediately; fetch restarts at RESET_PC.
